router_ctrl: RTL and testbench
==============================

Name: router_ctrl

Overview:
- Control block for the 1x3 router.
- Sequences each incoming packet: decodes the destination from the header, steers write enables to one of three per-port FIFOs and stalls the source while the target FIFO is full.
- Generates the FIFO first-data tag and the parity-check strobe for the register block.
- Runs a per-port read-timeout watchdog that issues soft_reset to a FIFO whose data is not drained.

Parameters:
TIMEOUT, 30, cycles vld_out[i] may stay high with no read_enb[i] before soft_reset[i] fires (2..2**TMR_W)
TMR_W, 5, width of each watchdog counter

Ports:
clock  in  1  clock, all logic on rising edge
resetn  in  1  reset, synchronous, active-low
pkt_valid  in  1  source drives header/payload; deasserts with the parity byte
data_in  in  8  source byte; [1:0] is the destination address during the header
fifo_full  in  3  full flags of FIFOs 0..2
fifo_empty  in  3  empty flags of FIFOs 0..2
read_enb  in  3  per-port read strobes from destinations
parity_done  in  1  register block has captured the parity byte
low_pkt_valid  in  1  register block saw pkt_valid fall during a full stall
write_enb  out  3  one-hot FIFO write enable
soft_reset  out  3  one-cycle per-port soft reset pulse
vld_out  out  3  data available to destination i
busy  out  1  source must hold its byte
detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg  out  1 each  state decodes

Behaviour:
- Reset (resetn=0 at an edge): state=DECODE_ADDRESS, addr_reg=0, watchdog counters=0, soft_reset=0. All outputs are Moore/combinational, so after reset detect_add=1, busy=0 and write_enb=0.
- vld_out[i] = ~fifo_empty[i].
- write_enb = write_enb_reg ? (3'b001 << addr_reg) : 0.
- addr_reg is loaded from data_in[1:0] only in DECODE_ADDRESS when pkt_valid=1.
- DECODE_ADDRESS: detect_add=1, busy=0.
  - pkt_valid and addr=3 -> DROP.
  - pkt_valid and fifo_empty[addr] -> LOAD_FIRST_DATA.
  - pkt_valid and FIFO not empty -> WAIT_TILL_EMPTY.
  - Otherwise stay.
- DROP: busy=0, no writes. Stay while pkt_valid=1; on pkt_valid=0 -> DECODE_ADDRESS, and the parity byte is discarded.
- WAIT_TILL_EMPTY: busy=1. fifo_empty[addr_reg] -> LOAD_FIRST_DATA.
- LOAD_FIRST_DATA: lfd_state=1, busy=1. Always -> LOAD_DATA. The FIFO tags the word written in the next cycle, which is the header, as first data.
- LOAD_DATA: ld_state=1, busy=0, write_enb_reg=1.
  - fifo_full[addr_reg] -> FIFO_FULL_STATE.
  - else pkt_valid=0 -> LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: full_state=1, busy=1, write_enb_reg=0. ~fifo_full[addr_reg] -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL: laf_state=1, busy=1, write_enb_reg=1.
  - parity_done -> DECODE_ADDRESS.
  - else low_pkt_valid -> LOAD_PARITY.
  - else -> LOAD_DATA.
- LOAD_PARITY: busy=1, write_enb_reg=1. Always -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: rst_int_reg=1, busy=1.
  - fifo_full[addr_reg] -> FIFO_FULL_STATE.
  - else -> DECODE_ADDRESS.
- Watchdog, per port i:
  - Counter clears when fifo_empty[i]=1 or read_enb[i]=1.
  - Otherwise it increments each cycle.
  - When the counter equals TIMEOUT-1 and no clear is active, soft_reset[i]=1 for exactly that next cycle and the counter returns to 0.
  - A read on the same edge wins: no pulse.
- Abort: soft_reset[addr_reg]=1 in any state other than DECODE_ADDRESS and DROP forces DECODE_ADDRESS on the next edge, overriding all other transitions. soft_reset on other ports does not affect the FSM.
- Simultaneous events: fifo_full takes priority over pkt_valid=0 in LOAD_DATA; parity_done takes priority over low_pkt_valid in LOAD_AFTER_FULL.
- Reset has priority over everything, including mid-packet.

Test Plan:
- Header 8'h0D (len 3, addr 1), all FIFOs empty, 3 payload bytes then parity -> states DECODE, LFD, LOAD_DATA x4, LOAD_PARITY, CHECK, DECODE; write_enb=3'b010 for 5 cycles; busy=0 only in LOAD_DATA.
- Same packet with fifo_full[1] rising on the 2nd payload byte -> FIFO_FULL_STATE, busy=1, write_enb=0 until full drops, then one LOAD_AFTER_FULL cycle -> LOAD_DATA; no byte lost.
- Header with addr 2 while fifo_empty[2]=0 -> WAIT_TILL_EMPTY, busy=1; fifo_empty[2]->1 -> LOAD_FIRST_DATA next edge.
- Header 8'h07 (addr 3) -> DROP; write_enb stays 0 through the whole packet; DECODE_ADDRESS the cycle after pkt_valid falls.
- fifo_empty[0]=0, read_enb[0]=0 for 30 cycles -> soft_reset[0] one-cycle pulse on cycle 30. A repeat with read_enb[0] pulsed at cycle 29 -> no pulse. Pulse while addr_reg=0 in LOAD_DATA -> DECODE_ADDRESS next edge.
- resetn=0 asserted in FIFO_FULL_STATE -> DECODE_ADDRESS, detect_add=1, write_enb=0, soft_reset=0 after one edge.

Source files
------------

// File: rtl/router_ctrl_if.sv
// router_ctrl_if: signal bundle between the 1x3 router control block and the
// source, register block, FIFOs and destinations around it.
//
// Signals (direction as seen by the router controller, modport slave):
//   pkt_valid      in   source is driving header/payload, falls with parity
//   data_in[7:0]   in   source byte, [1:0] = destination during the header
//   fifo_full[2:0] in   full flags of FIFOs 0..2
//   fifo_empty[2:0]in   empty flags of FIFOs 0..2
//   read_enb[2:0]  in   per-port read strobes from the destinations
//   parity_done    in   register block has captured the parity byte
//   low_pkt_valid  in   register block saw pkt_valid fall during a full stall
//   write_enb[2:0] out  one-hot FIFO write enable
//   soft_reset[2:0]out  one-cycle per-port watchdog reset pulse
//   vld_out[2:0]   out  data available to destination i
//   busy           out  source must hold its byte
//   detect_add, lfd_state, ld_state, laf_state, full_state,
//   rst_int_reg, write_enb_reg  out  state decodes for the register block
interface router_ctrl_if;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [2:0] write_enb;
    logic [2:0] soft_reset;
    logic [2:0] vld_out;
    logic       busy;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       write_enb_reg;

    // Environment side: drives the packet source, FIFO flags and strobes.
    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
               parity_done, low_pkt_valid,
        input  write_enb, soft_reset, vld_out, busy, detect_add, lfd_state,
               ld_state, laf_state, full_state, rst_int_reg, write_enb_reg
    );

    // Router controller side.
    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
               parity_done, low_pkt_valid,
        output write_enb, soft_reset, vld_out, busy, detect_add, lfd_state,
               ld_state, laf_state, full_state, rst_int_reg, write_enb_reg
    );
endinterface

// File: rtl/router_ctrl.sv
// router_ctrl: packet sequencer and per-port read watchdog for the 1x3 router.
// Decodes the destination from the header byte, steers one-hot write enables
// to the target FIFO, stalls the source while that FIFO is full, and issues a
// one-cycle soft_reset to any FIFO whose data sits unread for TIMEOUT cycles.
//
// Ports:
//   clock   in  rising-edge clock
//   resetn  in  synchronous active-low reset
//   bus     router_ctrl_if.slave (packet, FIFO flag, strobe and decode signals)
//
// Parameters:
//   TIMEOUT  cycles vld_out[i] may stay high with no read before soft_reset[i]
//   TMR_W    width of each watchdog counter (TIMEOUT <= 2**TMR_W)
//
// state              | meaning
// -------------------+--------------------------------------------------------
// DECODE_ADDRESS     | idle, waiting for a header; latches destination
// DROP               | header addressed port 3, swallow packet until pkt_valid=0
// WAIT_TILL_EMPTY    | target FIFO still holds data, stall source
// LOAD_FIRST_DATA    | one-cycle stall; next write (header) is tagged first data
// LOAD_DATA          | header/payload bytes written each cycle
// FIFO_FULL_STATE    | target FIFO full, writes stopped, source stalled
// LOAD_AFTER_FULL    | write the byte held during the stall, then resume
// LOAD_PARITY        | write the parity byte
// CHECK_PARITY_ERROR | register block compares parity; back to idle
module router_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int TMR_W   = 5
) (
    input  logic         clock,
    input  logic         resetn,
    router_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        DECODE_ADDRESS,
        DROP,
        WAIT_TILL_EMPTY,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR
    } state_t;

    localparam logic [TMR_W-1:0] WD_LAST = TMR_W'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_addr;
    logic [2:0] w_soft_reset;

    // Address 3 is not a real port: pad the per-port vectors to four entries
    // so indexing by a 2-bit address is always in range. Port 3 reads as
    // "empty", "not full" and "no soft reset".
    logic [3:0] w_empty_ext;
    logic [3:0] w_full_ext;
    logic [3:0] w_sr_ext;
    logic       w_abort;
    logic       w_unused;

    logic w_busy;
    logic w_detect_add;
    logic w_lfd_state;
    logic w_ld_state;
    logic w_laf_state;
    logic w_full_state;
    logic w_rst_int_reg;
    logic w_write_enb_reg;

    assign w_empty_ext = {1'b1, bus.fifo_empty};
    assign w_full_ext  = {1'b0, bus.fifo_full};
    assign w_sr_ext    = {1'b0, w_soft_reset};
    assign w_abort     = w_sr_ext[r_addr];
    assign w_unused    = &{1'b0, bus.data_in[7:2]};

    // ---------------- per-port read watchdog ----------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_wd
        logic [TMR_W-1:0] r_cnt;
        logic             r_sr;
        logic             w_clear;

        // A read on the terminal edge counts as a clear, so it suppresses the pulse.
        assign w_clear = bus.fifo_empty[gi] | bus.read_enb[gi];

        always_ff @(posedge clock) begin
            if (!resetn) begin
                r_cnt <= '0;
                r_sr  <= 1'b0;
            end else if (w_clear) begin
                r_cnt <= '0;
                r_sr  <= 1'b0;
            end else if (r_cnt == WD_LAST) begin
                r_cnt <= '0;
                r_sr  <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
                r_sr  <= 1'b0;
            end
        end

        assign w_soft_reset[gi] = r_sr;
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_addr <= 2'd0;
        end else if (r_state == DECODE_ADDRESS && bus.pkt_valid) begin
            r_addr <= bus.data_in[1:0];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DECODE_ADDRESS: begin
                if (bus.pkt_valid) begin
                    if (bus.data_in[1:0] == 2'd3)
                        w_next = DROP;
                    else if (w_empty_ext[bus.data_in[1:0]])
                        w_next = LOAD_FIRST_DATA;
                    else
                        w_next = WAIT_TILL_EMPTY;
                end
            end
            DROP: begin
                if (!bus.pkt_valid)
                    w_next = DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (w_empty_ext[r_addr])
                    w_next = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: begin
                w_next = LOAD_DATA;
            end
            LOAD_DATA: begin
                if (w_full_ext[r_addr])
                    w_next = FIFO_FULL_STATE;
                else if (!bus.pkt_valid)
                    w_next = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!w_full_ext[r_addr])
                    w_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (bus.parity_done)
                    w_next = DECODE_ADDRESS;
                else if (bus.low_pkt_valid)
                    w_next = LOAD_PARITY;
                else
                    w_next = LOAD_DATA;
            end
            LOAD_PARITY: begin
                w_next = CHECK_PARITY_ERROR;
            end
            CHECK_PARITY_ERROR: begin
                if (w_full_ext[r_addr])
                    w_next = FIFO_FULL_STATE;
                else
                    w_next = DECODE_ADDRESS;
            end
            default: begin
                w_next = DECODE_ADDRESS;
            end
        endcase

        // The destination FIFO was flushed under us: abandon the packet.
        if (w_abort && r_state != DECODE_ADDRESS && r_state != DROP)
            w_next = DECODE_ADDRESS;
    end

    always_comb begin
        w_busy          = 1'b0;
        w_detect_add    = 1'b0;
        w_lfd_state     = 1'b0;
        w_ld_state      = 1'b0;
        w_laf_state     = 1'b0;
        w_full_state    = 1'b0;
        w_rst_int_reg   = 1'b0;
        w_write_enb_reg = 1'b0;
        case (r_state)
            DECODE_ADDRESS:     w_detect_add = 1'b1;
            DROP:               w_busy       = 1'b0;
            WAIT_TILL_EMPTY:    w_busy       = 1'b1;
            LOAD_FIRST_DATA: begin
                w_lfd_state = 1'b1;
                w_busy      = 1'b1;
            end
            LOAD_DATA: begin
                w_ld_state      = 1'b1;
                w_write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: begin
                w_full_state = 1'b1;
                w_busy       = 1'b1;
            end
            LOAD_AFTER_FULL: begin
                w_laf_state     = 1'b1;
                w_busy          = 1'b1;
                w_write_enb_reg = 1'b1;
            end
            LOAD_PARITY: begin
                w_busy          = 1'b1;
                w_write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: begin
                w_rst_int_reg = 1'b1;
                w_busy        = 1'b1;
            end
            default: w_busy = 1'b0;
        endcase
    end

    assign bus.write_enb     = w_write_enb_reg ? (3'b001 << r_addr) : 3'b000;
    assign bus.soft_reset    = w_soft_reset;
    assign bus.vld_out       = ~bus.fifo_empty;
    assign bus.busy          = w_busy;
    assign bus.detect_add    = w_detect_add;
    assign bus.lfd_state     = w_lfd_state;
    assign bus.ld_state      = w_ld_state;
    assign bus.laf_state     = w_laf_state;
    assign bus.full_state    = w_full_state;
    assign bus.rst_int_reg   = w_rst_int_reg;
    assign bus.write_enb_reg = w_write_enb_reg;

endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: directed bench for router_ctrl. Each step drives one cycle of
// inputs, queues the outputs expected after the next rising edge, then pops
// and compares them against the DUT shortly after that edge.
module tb_router_ctrl;

    // Decode vector: {detect_add, lfd_state, ld_state, laf_state,
    //                 full_state, rst_int_reg, write_enb_reg}
    localparam logic [6:0] S_DEC = 7'b1000000;
    localparam logic [6:0] S_LFD = 7'b0100000;
    localparam logic [6:0] S_LD  = 7'b0010001;
    localparam logic [6:0] S_LAF = 7'b0001001;
    localparam logic [6:0] S_FUL = 7'b0000100;
    localparam logic [6:0] S_LP  = 7'b0000001;
    localparam logic [6:0] S_CHK = 7'b0000010;
    localparam logic [6:0] S_IDL = 7'b0000000;   // WAIT_TILL_EMPTY or DROP

    logic clock;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [16:0] sb_q[$];

    router_ctrl_if bus ();

    router_ctrl #(.TIMEOUT(30), .TMR_W(5)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1);
    end

    // Expected record: {decodes[6:0], busy, write_enb[2:0], soft_reset[2:0], vld_out[2:0]}
    function automatic logic [16:0] ex(input logic [6:0] st, input logic b,
                                       input logic [2:0] we, input logic [2:0] sr,
                                       input logic [2:0] vld);
        return {st, b, we, sr, vld};
    endfunction

    task automatic step(input string tag, input logic rstn, input logic pv,
                        input logic [7:0] din, input logic [2:0] full,
                        input logic [2:0] empty, input logic [2:0] renb,
                        input logic pd, input logic lpv, input logic [16:0] exp_v);
        logic [16:0] obs;
        logic [16:0] want;
        resetn            = rstn;
        bus.pkt_valid     = pv;
        bus.data_in       = din;
        bus.fifo_full     = full;
        bus.fifo_empty    = empty;
        bus.read_enb      = renb;
        bus.parity_done   = pd;
        bus.low_pkt_valid = lpv;
        sb_q.push_back(exp_v);
        @(posedge clock);
        #1;
        obs = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
               bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy,
               bus.write_enb, bus.soft_reset, bus.vld_out};
        want = sb_q.pop_front();
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%b required=%b", tag, obs, want);
        end
    endtask

    initial begin
        // reset
        step("reset", 0, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_DEC, 0, 3'b000, 3'b000, 3'b000));
        step("idle", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_DEC, 0, 3'b000, 3'b000, 3'b000));

        // packet to port 1, all FIFOs empty
        step("t1_lfd", 1, 1, 8'h0D, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LFD, 1, 3'b000, 3'b000, 3'b000));
        for (int i = 0; i < 4; i++)
            step("t1_ld", 1, 1, 8'h0D, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LD, 0, 3'b010, 3'b000, 3'b000));
        step("t1_lp", 1, 0, 8'hA5, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LP, 1, 3'b010, 3'b000, 3'b000));
        step("t1_chk", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_CHK, 1, 3'b000, 3'b000, 3'b000));
        step("t1_dec", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_DEC, 0, 3'b000, 3'b000, 3'b000));

        // packet to port 1 with full stalls and priority cases
        step("t2_lfd", 1, 1, 8'h0D, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LFD, 1, 3'b000, 3'b000, 3'b000));
        step("t2_ld1", 1, 1, 8'h0D, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LD, 0, 3'b010, 3'b000, 3'b000));
        step("t2_ld2", 1, 1, 8'h11, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LD, 0, 3'b010, 3'b000, 3'b000));
        step("t2_full", 1, 1, 8'h22, 3'b010, 3'b111, 3'b000, 0, 0, ex(S_FUL, 1, 3'b000, 3'b000, 3'b000));
        step("t2_hold", 1, 1, 8'h22, 3'b010, 3'b111, 3'b000, 0, 0, ex(S_FUL, 1, 3'b000, 3'b000, 3'b000));
        step("t2_laf", 1, 1, 8'h22, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LAF, 1, 3'b010, 3'b000, 3'b000));
        step("t2_resume", 1, 1, 8'h33, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LD, 0, 3'b010, 3'b000, 3'b000));
        step("t2_full_prio", 1, 0, 8'h44, 3'b010, 3'b111, 3'b000, 0, 0, ex(S_FUL, 1, 3'b000, 3'b000, 3'b000));
        step("t2_laf2", 1, 0, 8'h44, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LAF, 1, 3'b010, 3'b000, 3'b000));
        step("t2_lpv", 1, 0, 8'h44, 3'b000, 3'b111, 3'b000, 0, 1, ex(S_LP, 1, 3'b010, 3'b000, 3'b000));
        step("t2_chk", 1, 0, 8'h00, 3'b010, 3'b111, 3'b000, 0, 0, ex(S_CHK, 1, 3'b000, 3'b000, 3'b000));
        step("t2_chk_full", 1, 0, 8'h00, 3'b010, 3'b111, 3'b000, 0, 0, ex(S_FUL, 1, 3'b000, 3'b000, 3'b000));
        step("t2_laf3", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LAF, 1, 3'b010, 3'b000, 3'b000));
        step("t2_pd_prio", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 1, 1, ex(S_DEC, 0, 3'b000, 3'b000, 3'b000));

        // packet to port 2 while FIFO 2 still holds data
        step("t3_wait", 1, 1, 8'h0E, 3'b000, 3'b011, 3'b000, 0, 0, ex(S_IDL, 1, 3'b000, 3'b000, 3'b100));
        step("t3_wait2", 1, 1, 8'h0E, 3'b000, 3'b011, 3'b000, 0, 0, ex(S_IDL, 1, 3'b000, 3'b000, 3'b100));
        step("t3_lfd", 1, 1, 8'h0E, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LFD, 1, 3'b000, 3'b000, 3'b000));
        step("t3_ld", 1, 1, 8'h0E, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LD, 0, 3'b100, 3'b000, 3'b000));
        step("t3_lp", 1, 0, 8'h5A, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LP, 1, 3'b100, 3'b000, 3'b000));
        step("t3_chk", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_CHK, 1, 3'b000, 3'b000, 3'b000));
        step("t3_dec", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_DEC, 0, 3'b000, 3'b000, 3'b000));

        // packet to invalid port 3 is dropped
        step("t4_drop", 1, 1, 8'h07, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_IDL, 0, 3'b000, 3'b000, 3'b000));
        for (int i = 0; i < 2; i++)
            step("t4_drop_hold", 1, 1, 8'h99, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_IDL, 0, 3'b000, 3'b000, 3'b000));
        step("t4_dec", 1, 0, 8'h77, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_DEC, 0, 3'b000, 3'b000, 3'b000));
        step("t4_idle", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_DEC, 0, 3'b000, 3'b000, 3'b000));

        // watchdog: port 0 left unread fires after 30 edges
        for (int k = 1; k <= 31; k++)
            step("t5_wd", 1, 0, 8'h00, 3'b000, 3'b110, 3'b000, 0, 0,
                 ex(S_DEC, 0, 3'b000, (k == 30) ? 3'b001 : 3'b000, 3'b001));
        step("t5_clr", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_DEC, 0, 3'b000, 3'b000, 3'b000));

        // watchdog: a read at cycle 29 restarts the count
        for (int k = 1; k <= 31; k++)
            step("t5_rd29", 1, 0, 8'h00, 3'b000, 3'b110, (k == 29) ? 3'b001 : 3'b000, 0, 0,
                 ex(S_DEC, 0, 3'b000, 3'b000, 3'b001));
        step("t5_clr2", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_DEC, 0, 3'b000, 3'b000, 3'b000));

        // watchdog: a read on the terminal edge suppresses the pulse
        for (int k = 1; k <= 31; k++)
            step("t5_rd30", 1, 0, 8'h00, 3'b000, 3'b110, (k == 30) ? 3'b001 : 3'b000, 0, 0,
                 ex(S_DEC, 0, 3'b000, 3'b000, 3'b001));
        step("t5_clr3", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_DEC, 0, 3'b000, 3'b000, 3'b000));

        // watchdog pulse on the active port aborts the packet
        step("t6_lfd", 1, 1, 8'h04, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LFD, 1, 3'b000, 3'b000, 3'b000));
        for (int k = 1; k <= 30; k++)
            step("t6_ld", 1, 1, 8'h04, 3'b000, 3'b110, 3'b000, 0, 0,
                 ex(S_LD, 0, 3'b001, (k == 30) ? 3'b001 : 3'b000, 3'b001));
        step("t6_abort", 1, 1, 8'h04, 3'b000, 3'b110, 3'b000, 0, 0, ex(S_DEC, 0, 3'b000, 3'b000, 3'b001));
        step("t6_idle", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_DEC, 0, 3'b000, 3'b000, 3'b000));

        // reset while stalled on a full FIFO
        step("t7_lfd", 1, 1, 8'h0D, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LFD, 1, 3'b000, 3'b000, 3'b000));
        step("t7_ld", 1, 1, 8'h0D, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_LD, 0, 3'b010, 3'b000, 3'b000));
        step("t7_full", 1, 1, 8'h11, 3'b010, 3'b111, 3'b000, 0, 0, ex(S_FUL, 1, 3'b000, 3'b000, 3'b000));
        step("t7_reset", 0, 1, 8'h11, 3'b010, 3'b111, 3'b000, 0, 0, ex(S_DEC, 0, 3'b000, 3'b000, 3'b000));
        step("t7_after", 1, 0, 8'h00, 3'b000, 3'b111, 3'b000, 0, 0, ex(S_DEC, 0, 3'b000, 3'b000, 3'b000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
